boid_readback_dma: RTL and testbench
====================================

Name: boid_readback_dma

Overview:
- Reverse path of the CPU→BPU position write: on a CPU request, walks every BPU and writes each boid's current x/y back into processor data memory.
- The boid-update program then reads neighbour positions with ordinary loads.
- Sits between the BPU read mux (boid select → x_loc/y_loc) and the dmem write port, which it borrows only while mem_grant is high.
- Words are packed in the same fixed-point layout the CPU uses when writing positions, so a readback is bit-compatible with the CPU's own copy.

Parameters:
- MAX_BOIDS, 4, number of BPUs scanned per request.
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS), width of the boid select.
- ADDR_WIDTH, 12, dmem word-address width.

Ports:
- clock  in  1  system clock (50 MHz domain, same as processor).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request pulse from CPU-side decode.
- base_addr  in  ADDR_WIDTH  dmem word address of the first boid record; sampled on accepted start.
- mem_grant  in  1  dmem port free this cycle; a write commits only when high.
- x_loc_in  in  10  x of the currently selected boid, from the BPU mux.
- y_loc_in  in  9  y of the currently selected boid, from the BPU mux.
- boid_sel  out  BITS_FOR_BOIDS  drives the BPU read-mux select.
- mem_we  out  1  dmem write enable.
- mem_addr  out  ADDR_WIDTH  dmem write address.
- mem_data  out  32  dmem write data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has committed.

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE; internal counter and address registers clear to 0. Reset mid-scan aborts immediately with no further writes.
- States:
  - IDLE: start=1 → latch base_addr, idx=0 → SEL. start while not IDLE is ignored, with no queuing.
  - SEL: boid_sel=idx. Wait exactly one cycle for mux settle → CAP.
  - CAP: register x_loc_in, y_loc_in → WR_X.
  - WR_X:
    - mem_we=mem_grant, mem_addr=base+2*idx, mem_data={6'b0, x[9:0], 16'b0} (x in bits [25:16]).
    - Advance to WR_Y only in a cycle with mem_grant=1; otherwise hold all outputs stable with mem_we=0.
  - WR_Y:
    - mem_addr=base+2*idx+1, mem_data={6'b0, y[8:0], 17'b0} (y in bits [25:17]).
    - Stalls on mem_grant the same way as WR_X.
    - On commit: if idx==MAX_BOIDS-1 → FIN, else idx+1 → SEL.
  - FIN: done=1 for one cycle, busy=0 → IDLE. A start arriving in the FIN cycle is ignored.
- Address arithmetic: modulo 2^ADDR_WIDTH, so base=0xFFF wraps to 0x000. No bounds check.
- Latency with grant held high: 4 cycles per boid, plus 1 cycle for FIN. MAX_BOIDS=4 gives 17 cycles from start to done.
- boid_sel holds its value from SEL through WR_Y. Captured x/y are unaffected by BPU updates after CAP.
- mem_we is never high outside WR_X/WR_Y, and never high while mem_grant=0.

Optional Feature:
- Macro: READBACK_CHECKSUM_EN.
- Defined:
  - A 32-bit XOR accumulator clears on accepted start and XORs in every committed mem_data word.
  - After the last WR_Y, an extra state WR_CK writes the accumulator to base+2*MAX_BOIDS, with the same grant-stall rule; then FIN.
  - Latency becomes 18 cycles.
- Undefined: no accumulator and no WR_CK state; WR_Y goes directly to FIN.

Test Plan:
- Reset, then idle 10 cycles → busy=0, done=0, mem_we=0 throughout.
- Boid i at x=100+i, y=50+i, base=0x200, grant=1, pulse start → 8 writes:
  - 0x200=0x00640000, 0x201=0x00640000 (y=50<<17), … 0x207 holds y=53<<17.
  - done exactly 17 cycles after start.
- Same stimulus with mem_grant low for 3 cycles at the second WR_X → mem_we=0 during the stall, addr/data stable, done at cycle 20, data identical to the previous case.
- base=0xFFE → writes go to 0xFFE, 0xFFF, 0x000 … 0x005.
- Second start pulse at cycle 5 of a scan → ignored, exactly 8 writes; reset asserted at cycle 9 → no further mem_we, busy=0 next cycle.
- With READBACK_CHECKSUM_EN: scenario 2 adds a write to 0x208 equal to the XOR of the 8 data words; done at cycle 18.

Source files
------------

// File: rtl/boid_readback_dma.sv
// Boid position readback DMA: walks every BPU and writes each boid's x/y into dmem.
// Optional build macro READBACK_CHECKSUM_EN appends an XOR checksum word after the last boid.
module boid_readback_dma #(
    parameter int MAX_BOIDS      = 4,
    parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
    parameter int ADDR_WIDTH     = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic                      mem_grant,
    input  logic [9:0]                x_loc_in,
    input  logic [8:0]                y_loc_in,
    output logic [BITS_FOR_BOIDS-1:0] boid_sel,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [31:0]               mem_data,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CAP,
        S_WR_X,
        S_WR_Y,
`ifdef READBACK_CHECKSUM_EN
        S_WR_CK,
`endif
        S_FIN
    } state_t;

    localparam logic [BITS_FOR_BOIDS-1:0] LAST_IDX = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

    state_t                    state_q, state_d;
    logic [BITS_FOR_BOIDS-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [9:0]                x_q, x_d;
    logic [8:0]                y_q, y_d;
    logic [ADDR_WIDTH-1:0]     rec_addr;
`ifdef READBACK_CHECKSUM_EN
    logic [31:0]               acc_q, acc_d;
`endif

    // Each boid owns two consecutive words; address arithmetic wraps at 2^ADDR_WIDTH.
    assign rec_addr = base_q + (ADDR_WIDTH'(idx_q) << 1);
    assign boid_sel = idx_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        x_d      = x_q;
        y_d      = y_q;
`ifdef READBACK_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    idx_d   = '0;
`ifdef READBACK_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                busy    = 1'b1;
                state_d = S_CAP;
            end
            S_CAP: begin
                busy    = 1'b1;
                x_d     = x_loc_in;
                y_d     = y_loc_in;
                state_d = S_WR_X;
            end
            S_WR_X: begin
                busy     = 1'b1;
                mem_addr = rec_addr;
                mem_data = {6'b0, x_q, 16'b0};
                mem_we   = mem_grant;
                if (mem_grant) begin
`ifdef READBACK_CHECKSUM_EN
                    acc_d   = acc_q ^ mem_data;
`endif
                    state_d = S_WR_Y;
                end
            end
            S_WR_Y: begin
                busy     = 1'b1;
                mem_addr = rec_addr + ADDR_WIDTH'(1);
                mem_data = {6'b0, y_q, 17'b0};
                mem_we   = mem_grant;
                if (mem_grant) begin
`ifdef READBACK_CHECKSUM_EN
                    acc_d = acc_q ^ mem_data;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef READBACK_CHECKSUM_EN
                        state_d = S_WR_CK;
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEL;
                    end
                end
            end
`ifdef READBACK_CHECKSUM_EN
            S_WR_CK: begin
                busy     = 1'b1;
                mem_addr = base_q + ADDR_WIDTH'(2 * MAX_BOIDS);
                mem_data = acc_q;
                mem_we   = mem_grant;
                if (mem_grant) state_d = S_FIN;
            end
`endif
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A reset cycle must never commit a write or report activity.
        if (reset) begin
            mem_we   = 1'b0;
            mem_addr = '0;
            mem_data = '0;
            busy     = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
`ifdef READBACK_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            x_q     <= x_d;
            y_q     <= y_d;
`ifdef READBACK_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_boid_readback_dma.sv
// Self-checking bench for boid_readback_dma: directed scenarios plus randomized scans
// compared against a list-of-writes reference model.
module tb_boid_readback_dma;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

`ifdef READBACK_CHECKSUM_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic        mem_grant = 1'b1;
    logic [9:0]  x_loc_in;
    logic [8:0]  y_loc_in;
    logic [1:0]  boid_sel;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;

    logic [9:0]  x_arr [4];
    logic [8:0]  y_arr [4];

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_rel = -1;
    int          last_wr_rel = -1;
    bit          done_seen = 0;
    bit          in_scan = 0;
    int          mode = 0;
    logic [11:0] cur_base = '0;
    int          n_vec = 0;
    int          n_err = 0;

    boid_readback_dma dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .mem_grant (mem_grant),
        .x_loc_in  (x_loc_in),
        .y_loc_in  (y_loc_in),
        .boid_sel  (boid_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done)
    );

    // BPU read mux
    assign x_loc_in = x_arr[boid_sel];
    assign y_loc_in = y_arr[boid_sel];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the ordered list of dmem writes one scan must produce.
    function automatic void build_exp(input logic [11:0] base);
        logic [31:0] ck;
        logic [31:0] d;
        ck = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            d = 32'(x_arr[i]) << 16;
            exp_q.push_back('{base + 12'(2 * i), d});
            ck ^= d;
            d = 32'(y_arr[i]) << 17;
            exp_q.push_back('{base + 12'(2 * i + 1), d});
            ck ^= d;
        end
`ifdef READBACK_CHECKSUM_EN
        exp_q.push_back('{base + 12'd8, ck});
`endif
    endfunction

    always @(negedge clock) begin
        int rel;
        rel = cyc - start_cyc;
        if (mem_we) begin
            obs_q.push_back('{mem_addr, mem_data});
            last_wr_rel = rel;
        end
        if (done && in_scan && !done_seen) begin
            done_seen = 1;
            done_rel  = rel;
        end
        if (!mem_grant) check("we_without_grant", 32'(mem_we), 32'd0);
        if (in_scan && mode == 1 && rel >= 7 && rel <= 9) begin
            check("stall_addr", 32'(mem_addr), 32'(cur_base + 12'd2));
            check("stall_data", mem_data, 32'(x_arr[1]) << 16);
        end
    end

    // m: 0 grant always high, 1 grant low in cycles 7..9, 2 random grant.
    // exp_lat < 0 means: done must follow the last commit by one cycle.
    task automatic run_scan(input logic [11:0] base, input int m, input bit extra_start,
                            input int exp_lat);
        int rel;
        cur_base    = base;
        mode        = m;
        obs_q.delete();
        build_exp(base);
        done_seen   = 0;
        done_rel    = -1;
        last_wr_rel = -1;
        @(posedge clock); #1;
        start     = 1'b1;
        base_addr = base;
        mem_grant = 1'b1;
        @(negedge clock);
        start_cyc = cyc;
        in_scan   = 1;
        for (int k = 0; k < 300 && !done_seen; k++) begin
            @(posedge clock); #1;
            rel       = cyc - start_cyc;
            start     = extra_start && (rel == 5 || rel == 17);
            base_addr = 12'($urandom);
            case (m)
                1:       mem_grant = !(rel >= 7 && rel <= 9);
                2:       mem_grant = ($urandom_range(0, 3) != 0);
                default: mem_grant = 1'b1;
            endcase
        end
        in_scan   = 0;
        start     = 1'b0;
        mem_grant = 1'b1;
        if (!done_seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                check($sformatf("wr%0d_addr", i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
                check($sformatf("wr%0d_data", i), obs_q[i].data, exp_q[i].data);
            end
            if (exp_lat >= 0) check("done_latency", 32'(done_rel), 32'(exp_lat));
            else              check("done_after_last", 32'(done_rel), 32'(last_wr_rel + 1));
        end
        @(negedge clock);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int rel;
        for (int i = 0; i < 4; i++) begin
            x_arr[i] = 10'(100 + i);
            y_arr[i] = 9'(50 + i);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_we", 32'(mem_we), 32'd0);
        end

        run_scan(12'h200, 0, 0, LAT);
        run_scan(12'h200, 1, 0, LAT + 3);
        run_scan(12'hFFE, 0, 0, LAT);
        run_scan(12'h200, 0, 1, LAT);

        // Reset in cycle 9 of a scan: only boids 0 and 1 get written.
        obs_q.delete();
        @(posedge clock); #1;
        start     = 1'b1;
        base_addr = 12'h300;
        @(negedge clock);
        start_cyc = cyc;
        for (int k = 0; k < 9; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            rel   = cyc - start_cyc;
            if (rel == 9) reset = 1'b1;
        end
        @(negedge clock);
        check("reset_cycle_we", 32'(mem_we), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("busy_after_reset", 32'(busy), 32'd0);
        repeat (20) @(negedge clock);
        check("writes_before_reset", 32'(obs_q.size()), 32'd4);
        if (obs_q.size() == 4)
            check("last_pre_reset_addr", 32'(obs_q[3].addr), 32'h303);

        // Randomized scans with random positions, bases and grant patterns
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 4; i++) begin
                x_arr[i] = 10'($urandom);
                y_arr[i] = 9'($urandom);
            end
            run_scan(12'($urandom), (s == 0) ? 0 : 2, 0, (s == 0) ? LAT : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
